// File: rtl/sb_io.sv
// sb_io: bidirectional pad cell with optional output, output-enable and input
// registers. PIN_TYPE[5:2] selects the output mode, PIN_TYPE[1:0] the input mode.
// Unrecognised output codes behave as "output disabled"; input codes 10/11
// behave as the combinational input mode 01.
module sb_io #(
  parameter logic [5:0] PIN_TYPE = 6'b1010_01,
  parameter logic       PULLUP   = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic CLOCK_ENABLE,
  inout  wire  PACKAGE_PIN,
  input  logic OUTPUT_ENABLE,
  input  logic D_OUT_0,
  output logic D_IN_0
);

  localparam logic [3:0] OutMode = PIN_TYPE[5:2];
  localparam logic [1:0] InMode  = PIN_TYPE[1:0];

  localparam logic [3:0] OutDisabled = 4'b0000;
  localparam logic [3:0] OutComb     = 4'b0110;
  localparam logic [3:0] OutReg      = 4'b0101;
  localparam logic [3:0] OutTriComb  = 4'b1010;
  localparam logic [3:0] OutTriReg   = 4'b1101;
  localparam logic [1:0] InReg       = 2'b00;

  logic dout_q, dout_d;
  logic oe_q, oe_d;
  logic din_q, din_d;

  logic pad_en;
  logic pad_out;
  logic pad_val;

  // Select what (if anything) this cell drives onto the pad.
  always_comb begin
    pad_en  = 1'b0;
    pad_out = 1'b0;
    case (OutMode)
      OutComb: begin
        pad_en  = 1'b1;
        pad_out = D_OUT_0;
      end
      OutReg: begin
        pad_en  = 1'b1;
        pad_out = dout_q;
      end
      OutTriComb: begin
        pad_en  = OUTPUT_ENABLE;
        pad_out = D_OUT_0;
      end
      OutTriReg: begin
        pad_en  = oe_q;
        pad_out = dout_q;
      end
      OutDisabled: begin
        pad_en  = 1'b0;
        pad_out = 1'b0;
      end
      default: begin
        pad_en  = 1'b0;
        pad_out = 1'b0;
      end
    endcase
  end

  assign PACKAGE_PIN = pad_en ? pad_out : 1'bz;

  // Weak pull so an undriven pad resolves to 1.
  if (PULLUP) begin : g_pullup
    pullup u_pullup (PACKAGE_PIN);
  end

  // Resolved pad value; while driving, read back our own value directly.
  always_comb begin
    pad_val = pad_en ? pad_out : PACKAGE_PIN;
  end

  // Next-state for the three registers: load only when the clock is enabled.
  always_comb begin
    dout_d = dout_q;
    oe_d   = oe_q;
    din_d  = din_q;
    if (CLOCK_ENABLE) begin
      dout_d = D_OUT_0;
      oe_d   = OUTPUT_ENABLE;
      din_d  = pad_val;
    end
  end

  // State registers; reset clears them immediately and wins over a load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_q <= 1'b0;
      oe_q   <= 1'b0;
      din_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      oe_q   <= oe_d;
      din_q  <= din_d;
    end
  end

  // Input path: registered copy in mode 00, otherwise the live pad value.
  always_comb begin
    D_IN_0 = (InMode == InReg) ? din_q : pad_val;
  end

endmodule

// File: tb/tb_sb_io.sv
// Randomised scoreboard bench for sb_io. Five single cells in different modes
// share the control inputs, plus a 16-bit array of combinational tristate cells.
module tb_sb_io;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b1;
  logic        oe = 1'b0;
  logic        dout = 1'b0;
  logic [4:0]  ext_en = '0;
  logic [4:0]  ext_val = '0;
  logic [15:0] bus_dout = '0;
  logic [15:0] bus_ext_en = '0;
  logic [15:0] bus_ext_val = '0;

  wire  [4:0]  pad;
  wire  [15:0] bus_pad;
  logic [4:0]  din;
  logic [15:0] bus_din;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 5; i++) begin : g_ext
    assign pad[i] = ext_en[i] ? ext_val[i] : 1'bz;
  end

  for (genvar i = 0; i < 16; i++) begin : g_bus_ext
    assign bus_pad[i] = bus_ext_en[i] ? bus_ext_val[i] : 1'bz;
  end

  // [0] tristate comb, pull-up
  sb_io #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b1)) u_a (
    .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(pad[0]),
    .OUTPUT_ENABLE(oe), .D_OUT_0(dout), .D_IN_0(din[0]));
  // [1] tristate registered, registered input, pull-up
  sb_io #(.PIN_TYPE(6'b1101_00), .PULLUP(1'b1)) u_b (
    .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(pad[1]),
    .OUTPUT_ENABLE(oe), .D_OUT_0(dout), .D_IN_0(din[1]));
  // [2] always driven, registered data
  sb_io #(.PIN_TYPE(6'b0101_01), .PULLUP(1'b0)) u_c (
    .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(pad[2]),
    .OUTPUT_ENABLE(oe), .D_OUT_0(dout), .D_IN_0(din[2]));
  // [3] unknown output code (acts disabled), input code 10 (acts as 01), pull-up
  sb_io #(.PIN_TYPE(6'b1111_10), .PULLUP(1'b1)) u_d (
    .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(pad[3]),
    .OUTPUT_ENABLE(oe), .D_OUT_0(dout), .D_IN_0(din[3]));
  // [4] always driven comb, registered input
  sb_io #(.PIN_TYPE(6'b0110_00), .PULLUP(1'b0)) u_e (
    .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(pad[4]),
    .OUTPUT_ENABLE(oe), .D_OUT_0(dout), .D_IN_0(din[4]));

  for (genvar i = 0; i < 16; i++) begin : g_bus
    sb_io #(.PIN_TYPE(6'b1010_01), .PULLUP(1'b1)) u_bit (
      .clock(clk), .reset(rst), .CLOCK_ENABLE(ce), .PACKAGE_PIN(bus_pad[i]),
      .OUTPUT_ENABLE(oe), .D_OUT_0(bus_dout[i]), .D_IN_0(bus_din[i]));
  end

  typedef struct {
    logic [4:0]  pad;
    logic [4:0]  din;
    logic [15:0] bpad;
    logic [15:0] bdin;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state: what each cell last captured at an enabled edge.
  logic       m_dout = 1'b0;
  logic       m_oe = 1'b0;
  logic [4:0] m_din = '0;

  // Which cells drive the pad, given current inputs and captured state.
  function automatic logic [4:0] model_en();
    return {1'b1, 1'b0, 1'b1, m_oe, oe};
  endfunction

  // Level on each pad: own drive, else external driver, else pull-up.
  function automatic logic [4:0] model_pad();
    logic [4:0] en;
    logic [4:0] val;
    logic [4:0] r;
    en  = model_en();
    val = {dout, 1'b0, m_dout, m_dout, dout};
    for (int i = 0; i < 5; i++) r[i] = en[i] ? val[i] : (ext_en[i] ? ext_val[i] : 1'b1);
    return r;
  endfunction

  task automatic step(input logic r, input logic o, input logic d, input logic c,
                      input logic [4:0] xe, input logic [4:0] xv,
                      input logic [15:0] bd, input logic [15:0] bxe, input logic [15:0] bxv);
    exp_t e;
    logic [4:0] p;
    @(posedge clk);
    #1;
    // Account for the edge just taken, using the inputs that were present at it.
    if (rst) begin
      m_dout = 1'b0; m_oe = 1'b0; m_din = '0;
    end else if (ce) begin
      p = model_pad();
      m_din = p; m_dout = dout; m_oe = oe;
    end
    rst = r; oe = o; dout = d; ce = c;
    if (r) begin
      m_dout = 1'b0; m_oe = 1'b0; m_din = '0;
    end
    // External drivers only where the cell is released, so there is no contention.
    ext_en      = xe & ~model_en();
    ext_val     = xv;
    bus_dout    = bd;
    bus_ext_en  = o ? 16'h0000 : bxe;
    bus_ext_val = bxv;
    e.pad    = model_pad();
    e.din    = e.pad;
    e.din[1] = m_din[1];
    e.din[4] = m_din[4];
    for (int i = 0; i < 16; i++) e.bpad[i] = o ? bd[i] : (bus_ext_en[i] ? bxv[i] : 1'b1);
    e.bdin = e.bpad;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 5; i++) begin
          check($sformatf("pad%0d", i), {15'b0, pad[i]}, {15'b0, e.pad[i]});
          check($sformatf("din%0d", i), {15'b0, din[i]}, {15'b0, e.din[i]});
        end
        check("bus_pad", bus_pad, e.bpad);
        check("bus_din", bus_din, e.bdin);
      end
    end
  end

  initial begin : stim
    // Reset held: registered cells released / zero.
    step(1'b1, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
    // Release reset, request drive 1; external 0 on the still-released cell [1].
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b00010, 5'b00000, 16'h5A5A, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h5A5A, 16'h0000, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h5A5A, 16'h0000, 16'h0000);
    // Released pads: external 0 seen, then pull-up with no driver; bus reads A5A5.
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b11111, 5'b00000, 16'h0000, 16'hFFFF, 16'hA5A5);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b00000, 5'b00000, 16'h0000, 16'hFFFF, 16'hA5A5);
    // Clock enable low across one edge: registered pad holds 0, then follows.
    step(1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
    // Mid-cycle reset with registered pad at 1.
    step(1'b1, 1'b0, 1'b1, 1'b1, 5'b00000, 5'b00000, 16'h0000, 16'h0000, 16'h0000);
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), 5'($urandom), 5'($urandom),
           16'($urandom), 16'($urandom), 16'($urandom));
    end
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
